// File: rtl/tmds_pkg.sv
// tmds_pkg: constants and types shared by the TMDS receive path.
//  - TMDS_CTRL_xx : the four 10-bit control tokens (shared with tmds_encoder)
//  - tmds_state_e : word-alignment FSM states
package tmds_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [9:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [9:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [9:0] TMDS_CTRL_11 = 10'h2AB;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    LOCKED = 2'd2
  } tmds_state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational classification and decode of one TMDS symbol.
// Ports:
//  sym     in  10  TMDS symbol, bit 0 first on the wire
//  is_ctrl out 1   symbol is one of the four control tokens
//  ctrl    out 2   control value (meaningful when is_ctrl=1)
//  data    out 8   decoded pixel byte (meaningful when is_ctrl=0)
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic       is_ctrl,
  output logic [1:0] ctrl,
  output logic [7:0] data
);

  logic [7:0] q;

  always_comb begin
    is_ctrl = 1'b0;
    ctrl    = 2'b00;
    // Undo the optional inversion (bit 9), then undo the XOR/XNOR chain (bit 8).
    q       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = 8'h00;
    data[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    case (sym)
      TMDS_CTRL_00: begin is_ctrl = 1'b1; ctrl = 2'b00; end
      TMDS_CTRL_01: begin is_ctrl = 1'b1; ctrl = 2'b01; end
      TMDS_CTRL_10: begin is_ctrl = 1'b1; ctrl = 2'b10; end
      TMDS_CTRL_11: begin is_ctrl = 1'b1; ctrl = 2'b11; end
      default:      begin is_ctrl = 1'b0; ctrl = 2'b00; end
    endcase
  end

endmodule

// File: rtl/tmds_decoder.sv
// tmds_decoder: one TMDS channel receiver. Two-stage decode pipeline plus a
// word-alignment FSM that requests bitslips until control-token runs appear.
// Stream interface: one symbol per clk_pix cycle, no valid/ready; the
// deserialiser cannot be stalled, so every cycle carries a symbol.
// Ports:
//  clk_pix   in   1   pixel clock
//  rst       in   1   asynchronous active-high reset
//  sym_in    in   10  TMDS symbol from the 1:10 deserialiser
//  data_out  out  8   decoded pixel data (valid when de=1)
//  ctrl_out  out  2   decoded control bits (valid when de=0)
//  de        out  1   1 = data symbol, 0 = control token
//  locked    out  1   word alignment established
//  bitslip   out  1   one-cycle request to shift the word boundary
//  fsm_state out  2   alignment FSM state (debug)
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN       = 32,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int SLIP_WAIT      = 16,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic        clk_pix,
  input  logic        rst,
  input  logic [9:0]  sym_in,
  output logic [7:0]  data_out,
  output logic [1:0]  ctrl_out,
  output logic        de,
  output logic        locked,
  output logic        bitslip,
  output tmds_state_e fsm_state
);

  localparam int RUN_W = $clog2(CTRL_RUN) + 1;
  localparam int TMO_W = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int GAP_W = $clog2(LOSS_TIMEOUT) + 1;

  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(CTRL_RUN);
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(CTRL_RUN - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
  // tmo_cnt doubles as the settle timer while in SLIP.
  localparam logic [TMO_W-1:0] SLIP_LAST = TMO_W'(SLIP_WAIT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(LOSS_TIMEOUT - 1);

  logic       dec_is_ctrl;
  logic [1:0] dec_ctrl;
  logic [7:0] dec_data;

  tmds_symbol_decode u_sym_dec (
    .sym     (sym_in),
    .is_ctrl (dec_is_ctrl),
    .ctrl    (dec_ctrl),
    .data    (dec_data)
  );

  // Stage 1: classified symbol.
  logic       s1_is_ctrl;
  logic [1:0] s1_ctrl;
  logic [7:0] s1_data;

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      s1_is_ctrl <= 1'b0;
      s1_ctrl    <= 2'b00;
      s1_data    <= 8'h00;
    end else begin
      s1_is_ctrl <= dec_is_ctrl;
      s1_ctrl    <= dec_ctrl;
      s1_data    <= dec_data;
    end
  end

  // Stage 2: outputs. The field not carried by the current symbol holds.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      data_out <= 8'h00;
      ctrl_out <= 2'b00;
      de       <= 1'b0;
    end else begin
      de <= ~s1_is_ctrl;
      if (s1_is_ctrl) ctrl_out <= s1_ctrl;
      else            data_out <= s1_data;
    end
  end

  // Alignment FSM, driven by the stage-1 classification.
  tmds_state_e      state, state_nxt;
  logic [RUN_W-1:0] run_cnt, run_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             slip_req;

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      state   <= SEARCH;
      run_cnt <= '0;
      tmo_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_nxt;
      tmo_cnt <= tmo_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    tmo_nxt   = tmo_cnt;
    gap_nxt   = gap_cnt;
    slip_req  = 1'b0;
    case (state)
      SEARCH: begin
        if (s1_is_ctrl) run_nxt = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_W'(1);
        else            run_nxt = '0;
        tmo_nxt = (tmo_cnt == TMO_LAST) ? tmo_cnt : tmo_cnt + TMO_W'(1);
        // Lock is declared on the token that brings the run to CTRL_RUN, and
        // takes priority over a timeout landing in the same cycle.
        if (s1_is_ctrl && run_cnt >= RUN_LAST) begin
          state_nxt = LOCKED;
          tmo_nxt   = '0;
          gap_nxt   = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = SLIP;
          slip_req  = 1'b1;
          run_nxt   = '0;
          tmo_nxt   = '0;
        end
      end
      SLIP: begin
        run_nxt = '0;
        if (tmo_cnt == SLIP_LAST) begin
          state_nxt = SEARCH;
          tmo_nxt   = '0;
        end else begin
          tmo_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      LOCKED: begin
        // Lock drops on the data symbol that arrives with the gap already full.
        if (s1_is_ctrl) begin
          gap_nxt = '0;
        end else if (gap_cnt == GAP_LAST) begin
          state_nxt = SEARCH;
          run_nxt   = '0;
          tmo_nxt   = '0;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        state_nxt = SEARCH;
        run_nxt   = '0;
        tmo_nxt   = '0;
        gap_nxt   = '0;
      end
    endcase
  end

  // bitslip is asserted only in SEARCH; the next cycle is always SLIP, so
  // it can never be high on two consecutive cycles.
  assign bitslip   = slip_req;
  assign locked    = (state == LOCKED);
  assign fsm_state = state;

endmodule

// File: tb/tb_tmds_decoder.sv
module tb_tmds_decoder;
  import tmds_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk_pix = 1'b0;
  logic        rst     = 1'b1;
  logic [9:0]  sym_in  = 10'h100;
  logic [7:0]  data_out;
  logic [1:0]  ctrl_out;
  logic        de;
  logic        locked;
  logic        bitslip;
  tmds_state_e fsm_state;

  int total = 0;
  int bad   = 0;

  always #5 clk_pix = ~clk_pix;

  tmds_decoder dut (
    .clk_pix   (clk_pix),
    .rst       (rst),
    .sym_in    (sym_in),
    .data_out  (data_out),
    .ctrl_out  (ctrl_out),
    .de        (de),
    .locked    (locked),
    .bitslip   (bitslip),
    .fsm_state (fsm_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic send(input logic [9:0] s);
    @(negedge clk_pix);
    sym_in = s;
  endtask

  // Returns at the negedge where rst is released.
  task automatic do_reset();
    @(negedge clk_pix);
    rst    = 1'b1;
    sym_in = 10'h100;
    @(negedge clk_pix);
    rst = 1'b0;
  endtask

  function automatic logic [9:0] rand_data_sym();
    logic [9:0] s;
    s = 10'($urandom_range(0, 1023));
    if (s == TMDS_CTRL_00 || s == TMDS_CTRL_01 || s == TMDS_CTRL_10 || s == TMDS_CTRL_11)
      s = 10'h100;
    return s;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    send(10'h2AB);
    send(10'h30F);
    send(10'h30F);
    send(10'h30F);
    #1 rst = 1'b1;
    #1;
    total++;
    if (data_out !== 8'h00 || ctrl_out !== 2'b00 || de !== 1'b0 || locked !== 1'b0 || bitslip !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: data=%h ctrl=%b de=%b locked=%b bitslip=%b, required all 0",
               data_out, ctrl_out, de, locked, bitslip);
    end
    @(negedge clk_pix);
    rst = 1'b0;
    total++;
    if (fsm_state !== SEARCH) begin
      bad++;
      $display("FAIL reset_state: state=%0d required SEARCH", fsm_state);
    end
    send(10'h155);
    send(10'h100);
    send(10'h100);
    total++;
    if (de !== 1'b1 || data_out !== 8'hFF) begin
      bad++;
      $display("FAIL reset_first_sym: de=%b data=%h required de=1 data=ff", de, data_out);
    end
  endtask

  task automatic test_tokens();
    logic [9:0] seq [0:6];
    logic [1:0] exp_ctrl [0:6];
    seq      = '{10'h155, 10'h354, 10'h0AB, 10'h154, 10'h2AB, 10'h100, 10'h100};
    exp_ctrl = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
    for (int i = 0; i < 7; i++) begin
      send(seq[i]);
      if (i >= 3) begin
        total++;
        if (de !== 1'b0 || ctrl_out !== exp_ctrl[i-2] || data_out !== 8'hFF) begin
          bad++;
          $display("FAIL token_%0d: de=%b ctrl=%b data=%h required de=0 ctrl=%b data=ff",
                   i - 2, de, ctrl_out, data_out, exp_ctrl[i-2]);
        end
      end
    end
  endtask

  task automatic test_data();
    logic [9:0] seq  [0:8];
    logic       e_de [0:6];
    logic [7:0] e_d  [0:6];
    logic [1:0] e_c  [0:6];
    seq  = '{10'h2AB, 10'h100, 10'h2FF, 10'h1FF, 10'h30F, 10'h0AB, 10'h155, 10'h100, 10'h100};
    e_de = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    e_d  = '{8'h00, 8'h00, 8'hFE, 8'h01, 8'h10, 8'h10, 8'hFF};
    e_c  = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01};
    for (int i = 0; i < 9; i++) begin
      send(seq[i]);
      if (i == 2) begin
        // 10'h100 went in one cycle earlier; with 2-cycle latency the token still shows.
        total++;
        if (de !== 1'b0 || ctrl_out !== 2'b11) begin
          bad++;
          $display("FAIL data_latency_early: de=%b ctrl=%b required de=0 ctrl=11", de, ctrl_out);
        end
      end
      if (i >= 3) begin
        total++;
        if (de !== e_de[i-2] || data_out !== e_d[i-2] || ctrl_out !== e_c[i-2]) begin
          bad++;
          $display("FAIL data_%0d: de=%b data=%h ctrl=%b required de=%b data=%h ctrl=%b",
                   i - 2, de, data_out, ctrl_out, e_de[i-2], e_d[i-2], e_c[i-2]);
        end
      end
    end
  endtask

  task automatic test_lock();
    logic ok;
    do_reset();
    repeat (31) send(TMDS_CTRL_00);
    send(10'h100);
    ok = 1'b1;
    repeat (4) begin
      send(10'h100);
      if (locked !== 1'b0) ok = 1'b0;
    end
    for (int i = 0; i < 32; i++) begin
      send(TMDS_CTRL_00);
      if (locked !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL lock_short_run: locked rose before 32 consecutive tokens, required 0");
    end
    send(TMDS_CTRL_00);
    total++;
    if (locked !== 1'b0) begin
      bad++;
      $display("FAIL lock_not_early: locked=%b required 0", locked);
    end
    send(TMDS_CTRL_00);
    total++;
    if (locked !== 1'b1 || fsm_state !== LOCKED || bitslip !== 1'b0) begin
      bad++;
      $display("FAIL lock_rise: locked=%b state=%0d bitslip=%b required 1 LOCKED 0",
               locked, fsm_state, bitslip);
    end
  endtask

  task automatic test_slip();
    int   exp_q[$];
    int   got_q[$];
    logic prev;
    logic ok;
    exp_q = '{1023, 2063, 3103};
    do_reset();
    prev = 1'b0;
    ok   = 1'b1;
    for (int i = 1; i <= 3200; i++) begin
      send(rand_data_sym());
      if (bitslip === 1'b1) got_q.push_back(i);
      if (bitslip === 1'b1 && prev) ok = 1'b0;
      if (locked !== 1'b0) ok = 1'b0;
      prev = bitslip;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL slip_pulse_shape: consecutive bitslip or unexpected lock seen");
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL slip_count: pulses=%0d required %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if (k >= got_q.size()) begin
        bad++;
        $display("FAIL slip_pos_%0d: no pulse, required cycle %0d", k, exp_q[k]);
      end else if (got_q[k] != exp_q[k]) begin
        bad++;
        $display("FAIL slip_pos_%0d: cycle=%0d required %0d", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_loss();
    logic ok;
    do_reset();
    repeat (34) send(TMDS_CTRL_01);
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL loss_lock: locked=%b required 1", locked);
    end
    ok = 1'b1;
    repeat (4095) begin
      send(rand_data_sym());
      if (locked !== 1'b1 || bitslip !== 1'b0) ok = 1'b0;
    end
    repeat (4) begin
      send(TMDS_CTRL_10);
      if (locked !== 1'b1 || bitslip !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL loss_4095_hold: lock dropped or bitslip while locked, required locked=1");
    end
    ok = 1'b1;
    repeat (4096) begin
      send(rand_data_sym());
      if (locked !== 1'b1) ok = 1'b0;
    end
    send(10'h100);
    if (locked !== 1'b1) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL loss_early_drop: locked fell before 4096 data symbols");
    end
    send(10'h100);
    total++;
    if (locked !== 1'b0 || fsm_state !== SEARCH) begin
      bad++;
      $display("FAIL loss_drop: locked=%b state=%0d required 0 SEARCH", locked, fsm_state);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_tokens();
    test_data();
    test_lock();
    test_slip();
    test_loss();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
